trap_redirect: RTL and testbench

Trap/return redirect controller sitting directly downstream of the CSR unit in the execute stage. It consumes the CSR unit's `is_trap` / `is_mret` pulses and produces the corresponding fetch redirect:
- captures the target PC (trap vector from `mtvec`, or return address from `mepc`);
- flushes the younger pipeline stages;
- holds the pipeline stalled while fetch accepts the new PC and the front end drains.

---
 rtl/trap_redirect_pkg.sv | 20 ++
 rtl/trap_redirect_if.sv | 31 +++
 rtl/trap_target_calc.sv | 33 +++
 rtl/trap_redirect.sv | 70 +++++++
 tb/tb_trap_redirect.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/trap_redirect_pkg.sv
// Shared types and constants for the trap/return redirect controller.
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets).
package trap_redirect_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2,
        DRAIN    = 2'd3
    } trap_st_e;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
    localparam int         CAUSE_INT_BIT       = 31;

    // Fetch targets are always word aligned; the low CSR bits carry mode or are ignored.
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_redirect_if.sv
// CSR-event inputs and fetch/pipeline-control outputs of trap_redirect.
// master = CSR unit / fetch / pipeline side, slave = trap_redirect.
interface trap_redirect_if;

    logic        is_trap;
    logic        is_mret;
    logic [31:0] trap_cause;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        ifu_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic        flush_exe;
    logic        stall_pipe;
    logic        trap_busy;

    modport master (
        output is_trap, is_mret, trap_cause, mtvec, mepc, ifu_ready,
        input  redirect_valid, redirect_pc, flush_if, flush_id, flush_exe,
               stall_pipe, trap_busy
    );

    modport slave (
        input  is_trap, is_mret, trap_cause, mtvec, mepc, ifu_ready,
        output redirect_valid, redirect_pc, flush_if, flush_id, flush_exe,
               stall_pipe, trap_busy
    );

endinterface

// File: rtl/trap_target_calc.sv
// Combinational redirect-target selection: trap vector from mtvec or return address from mepc.
// TRAP_VECTORED_EN adds vectored-mode interrupt offsets; it is tested only here.
module trap_target_calc
    import trap_redirect_pkg::*;
(
    input  logic        is_trap,
    input  logic [31:0] trap_cause,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] target
);

`ifdef TRAP_VECTORED_EN
    logic unused_cause_bit;
    assign unused_cause_bit = trap_cause[30];

    always_comb begin
        // NOTE: assign a default first in every always_comb path so no latch is inferred.
        target = is_trap ? align4(mtvec) : align4(mepc);
        // Only interrupts in vectored mode get an offset; modes 10/11 fall back to the base.
        if (is_trap && (mtvec[1:0] == MTVEC_MODE_VECTORED) && trap_cause[CAUSE_INT_BIT])
            target = align4(mtvec) + {trap_cause[29:0], 2'b00};
    end
`else
    logic unused_direct_bits;
    assign unused_direct_bits = ^{trap_cause, mtvec[1:0]};

    always_comb begin
        target = is_trap ? align4(mtvec) : align4(mepc);
    end
`endif

endmodule

// File: rtl/trap_redirect.sv
// Trap/mret redirect controller: flush, redirect handshake with fetch, then drain stall.
// Vectored interrupt targets are enabled by defining TRAP_VECTORED_EN.
module trap_redirect
    import trap_redirect_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    trap_redirect_if.slave  bus
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    trap_st_e    state, state_nx;
    logic [3:0]  drain_cnt;
    logic [31:0] pc_q;
    logic [31:0] target;
    logic        event_in;
    logic        handshake;

    assign event_in  = bus.is_trap | bus.is_mret;
    assign handshake = (state == REDIRECT) && bus.ifu_ready;

    trap_target_calc u_target (
        .is_trap    (bus.is_trap),
        .trap_cause (bus.trap_cause),
        .mtvec      (bus.mtvec),
        .mepc       (bus.mepc),
        .target     (target)
    );

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (event_in) state_nx = FLUSH;
            FLUSH:    state_nx = REDIRECT;
            REDIRECT: if (bus.ifu_ready) state_nx = (DRAIN_LOAD == 4'd0) ? IDLE : DRAIN;
            DRAIN:    if (drain_cnt <= 4'd1) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  drain_cnt <= 4'd0;
        else if (handshake)         drain_cnt <= DRAIN_LOAD;
        else if (state == DRAIN)    drain_cnt <= drain_cnt - 4'd1;
    end

    // Target is captured only on the accepted event so later CSR writes cannot disturb it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                              pc_q <= 32'd0;
        else if ((state == IDLE) && event_in)   pc_q <= target;
    end

    assign bus.redirect_pc    = pc_q;
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.flush_if       = (state == FLUSH);
    assign bus.flush_id       = (state == FLUSH);
    assign bus.flush_exe      = (state == FLUSH);
    assign bus.stall_pipe     = (state != IDLE);
    assign bus.trap_busy      = (state != IDLE);

endmodule

// File: tb/tb_trap_redirect.sv
// Scoreboard bench for trap_redirect: stimulus queues expected redirect PCs, a monitor checks handshakes.
// Vectored-target vectors follow TRAP_VECTORED_EN.
module tb_trap_redirect;

    localparam int D = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    trap_redirect_if bus ();

    trap_redirect #(.DRAIN_CYCLES(D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // {flush_if, flush_id, flush_exe, redirect_valid, stall_pipe, trap_busy}
    function automatic logic [31:0] outs();
        return {26'd0, bus.flush_if, bus.flush_id, bus.flush_exe,
                bus.redirect_valid, bus.stall_pipe, bus.trap_busy};
    endfunction

    // Monitor: every accepted redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (rstn && bus.redirect_valid && bus.ifu_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got pc 0x%08h with no redirect expected", bus.redirect_pc);
            end else begin
                check("redirect_pc", bus.redirect_pc, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string name, input logic trap, input logic mret,
                           input logic [31:0] cause, input logic [31:0] tvec,
                           input logic [31:0] epc, input logic [31:0] exp_pc,
                           input int ready_lo, input bit inject_drain);
        int cycles;
        bus.is_trap    = trap;
        bus.is_mret    = mret;
        bus.trap_cause = cause;
        bus.mtvec      = tvec;
        bus.mepc       = epc;
        bus.ifu_ready  = (ready_lo == 0);
        exp_q.push_back(exp_pc);
        tick();
        bus.is_trap    = 1'b0;
        bus.is_mret    = 1'b0;
        bus.trap_cause = ~cause;
        bus.mtvec      = ~tvec;
        bus.mepc       = ~epc;
        @(negedge clk);
        check({name, "_flush"}, outs(), 32'b111011);
        tick();
        for (int k = 0; k < ready_lo; k++) begin
            @(negedge clk);
            check({name, "_bp_outs"}, outs(), 32'b000111);
            check({name, "_bp_pc"}, bus.redirect_pc, exp_pc);
            tick();
        end
        bus.ifu_ready = 1'b1;
        @(negedge clk);
        check({name, "_redirect"}, outs(), 32'b000111);
        tick();
        if (inject_drain) begin
            bus.is_trap = 1'b1;
            bus.mtvec   = 32'h0000_0F00;
        end
        @(negedge clk);
        check({name, "_post_hs"}, outs(), 32'b000011);
        cycles = 0;
        while (bus.stall_pipe && cycles < 20) begin
            cycles++;
            @(posedge clk);
            #1;
            bus.is_trap = 1'b0;
            @(negedge clk);
        end
        bus.is_trap = 1'b0;
        check({name, "_drain_len"}, 32'(cycles), 32'(D));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({name, "_idle_after"}, outs(), 32'd0);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn           = 1'b0;
        bus.is_trap    = 1'b0;
        bus.is_mret    = 1'b0;
        bus.trap_cause = 32'd0;
        bus.mtvec      = 32'd0;
        bus.mepc       = 32'd0;
        bus.ifu_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 32'd0);
        check("reset_pc", bus.redirect_pc, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        run_seq("ecall", 1'b1, 1'b0, 32'h0000_000B, 32'h8000_0100, 32'h0000_0000,
                32'h8000_0100, 0, 1'b0);
        run_seq("mret", 1'b0, 1'b1, 32'h0000_0000, 32'h8000_0100, 32'h0000_2046,
                32'h0000_2044, 0, 1'b0);
        run_seq("backpressure", 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0403, 32'h0000_0000,
                32'h0000_0400, 5, 1'b0);
        run_seq("simul", 1'b1, 1'b1, 32'h0000_0002, 32'h0000_0200, 32'h0000_0100,
                32'h0000_0200, 0, 1'b1);
`ifdef TRAP_VECTORED_EN
        run_seq("vec_int", 1'b1, 1'b0, 32'h8000_0007, 32'h8000_0001, 32'h0000_0000,
                32'h8000_001C, 0, 1'b0);
        run_seq("vec_exc", 1'b1, 1'b0, 32'h0000_000B, 32'h8000_0001, 32'h0000_0000,
                32'h8000_0000, 0, 1'b0);
`else
        run_seq("direct_int", 1'b1, 1'b0, 32'h8000_0007, 32'h8000_0001, 32'h0000_0000,
                32'h8000_0000, 0, 1'b0);
`endif

        // Reset while waiting in REDIRECT must drop everything at once.
        bus.is_trap   = 1'b1;
        bus.mtvec     = 32'h1234_5678;
        bus.ifu_ready = 1'b0;
        exp_q.push_back(32'h1234_5678);
        tick();
        bus.is_trap = 1'b0;
        tick();
        @(negedge clk);
        check("rst_pre_redirect", outs(), 32'b000111);
        check("rst_pre_pc", bus.redirect_pc, 32'h1234_5678);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 32'd0);
        check("rst_mid_pc", bus.redirect_pc, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        bus.ifu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_after_outs", outs(), 32'd0);
        end
        check("rst_after_pc", bus.redirect_pc, 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
